// File: rtl/rr_encoder_pkg.sv
// Shared definitions for the round-robin encoder: index widths and the
// rotate-then-priority-encode search used by the selector.
package rr_encoder_pkg;

  localparam int ENC_W = 4;
  localparam int DEC_W = 1 << ENC_W;

  // Returns {found, index}. The index is the first set bit of vec at or above
  // ptr, wrapping modulo DEC_W. The vector is rotated so that bit ptr lands at
  // position 0, the lowest set bit is found, and ptr is added back (the
  // ENC_W-bit sum wraps naturally).
  function automatic logic [ENC_W:0] rr_first(input logic [DEC_W-1:0] vec,
                                               input logic [ENC_W-1:0] ptr);
    logic [2*DEC_W-1:0] dbl;
    logic [DEC_W-1:0]   rot;
    logic [ENC_W-1:0]   idx;
    logic [ENC_W-1:0]   res;
    dbl = {vec, vec};
    rot = dbl[ptr +: DEC_W];
    idx = {ENC_W{1'b0}};
    for (int i = DEC_W - 1; i >= 0; i--) begin
      if (rot[i]) begin
        idx = ENC_W'(i);
      end else begin
        idx = idx;
      end
    end
    res = idx + ptr;
    return {|vec, res};
  endfunction

endpackage

// File: rtl/rr_encoder_pick.sv
// Combinational round-robin selector: picks the first pending bit at or above
// the pointer, wrapping around. Kept separate so arbiters can reuse it.
module rr_pick
  import rr_encoder_pkg::*;
(
  input  logic [DEC_W-1:0] pend,
  input  logic [ENC_W-1:0] ptr,
  output logic [ENC_W-1:0] sel,
  output logic             found
);

  // Search the pending vector starting at the pointer.
  always_comb begin
    {found, sel} = rr_first(pend, ptr);
  end

endmodule

// File: rtl/rr_encoder.sv
// Round-robin encoder: captures request pulses into a sticky pending vector
// and issues them one at a time as binary indices through a valid/ready
// output register.
module rr_encoder
  import rr_encoder_pkg::*;
#(
  parameter int EncodeWidth = ENC_W,
  localparam int DecodeWidth = 2 ** EncodeWidth
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   EN,
  input  logic [DecodeWidth-1:0] REQ,
  output logic [EncodeWidth-1:0] OUT,
  output logic                   VALID,
  input  logic                   READY,
  output logic [DecodeWidth-1:0] PEND
);

  logic [DecodeWidth-1:0] pend_r;
  logic [EncodeWidth-1:0] ptr_r;
  logic [EncodeWidth-1:0] out_r;
  logic                   valid_r;

  logic [EncodeWidth-1:0] sel_s;
  logic                   found_s;
  logic                   load_s;
  logic [DecodeWidth-1:0] clr_s;
  logic [DecodeWidth-1:0] set_s;
  logic [DecodeWidth-1:0] pend_next_s;

  rr_pick u_pick (
    .pend  (pend_r),
    .ptr   (ptr_r),
    .sel   (sel_s),
    .found (found_s)
  );

  // Load when the output stage is free or being drained and something is pending.
  always_comb begin
    load_s = (!valid_r || READY) && found_s;
  end

  // Next pending vector: clear the issued bit, then OR in new requests so a
  // same-cycle re-request of the issued bit keeps it pending.
  always_comb begin
    clr_s = {DecodeWidth{1'b0}};
    set_s = {DecodeWidth{1'b0}};
    if (load_s) begin
      clr_s = DecodeWidth'(1) << sel_s;
    end else begin
      clr_s = {DecodeWidth{1'b0}};
    end
    if (EN) begin
      set_s = REQ;
    end else begin
      set_s = {DecodeWidth{1'b0}};
    end
    pend_next_s = (pend_r & ~clr_s) | set_s;
  end

  // Pending vector, pointer and output register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pend_r  <= {DecodeWidth{1'b0}};
      ptr_r   <= {EncodeWidth{1'b0}};
      out_r   <= {EncodeWidth{1'b0}};
      valid_r <= 1'b0;
    end else begin
      pend_r <= pend_next_s;
      if (load_s) begin
        out_r   <= sel_s;
        valid_r <= 1'b1;
        ptr_r   <= sel_s + EncodeWidth'(1);
      end else if (valid_r && READY) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign OUT   = out_r;
  assign VALID = valid_r;
  assign PEND  = pend_r;

endmodule

// File: tb/tb_rr_encoder.sv
// Directed self-checking bench for rr_encoder.
module tb_rr_encoder;

  logic        CLK;
  logic        RST_N;
  logic        EN;
  logic [15:0] REQ;
  logic [3:0]  OUT;
  logic        VALID;
  logic        READY;
  logic [15:0] PEND;

  int checks = 0;
  int errors = 0;

  rr_encoder dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .EN    (EN),
    .REQ   (REQ),
    .OUT   (OUT),
    .VALID (VALID),
    .READY (READY),
    .PEND  (PEND)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] o, input logic [15:0] p);
    check({tag, ".valid"}, {15'd0, VALID}, {15'd0, v});
    check({tag, ".out"}, {12'd0, OUT}, {12'd0, o});
    check({tag, ".pend"}, PEND, p);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0; EN = 1'b0; REQ = 16'h0000; READY = 1'b1;

    // Reset then single request
    do_reset();
    chk_out("rst", 1'b0, 4'd0, 16'h0000);
    EN = 1'b1; REQ = 16'h0020;
    tick();
    chk_out("single.cap", 1'b0, 4'd0, 16'h0020);
    REQ = 16'h0000;
    tick();
    chk_out("single.load", 1'b1, 4'd5, 16'h0000);
    check("single.ptr", {12'd0, dut.ptr_r}, 16'd6);
    tick();
    chk_out("single.drop", 1'b0, 4'd5, 16'h0000);

    // Multi-hot burst, round robin from ptr 0
    do_reset();
    REQ = 16'h8421;
    tick();
    REQ = 16'h0000;
    tick();
    chk_out("burst.0", 1'b1, 4'd0, 16'h8420);
    tick();
    chk_out("burst.5", 1'b1, 4'd5, 16'h8400);
    tick();
    chk_out("burst.10", 1'b1, 4'd10, 16'h8000);
    tick();
    chk_out("burst.15", 1'b1, 4'd15, 16'h0000);
    tick();
    chk_out("burst.end", 1'b0, 4'd15, 16'h0000);

    // Backpressure
    do_reset();
    READY = 1'b0;
    REQ = 16'h8421;
    tick();
    REQ = 16'h0000;
    tick();
    chk_out("bp.load", 1'b1, 4'd0, 16'h8420);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("bp.hold", 1'b1, 4'd0, 16'h8420);
    end
    READY = 1'b1;
    tick();
    chk_out("bp.5", 1'b1, 4'd5, 16'h8400);
    tick();
    chk_out("bp.10", 1'b1, 4'd10, 16'h8000);
    tick();
    chk_out("bp.15", 1'b1, 4'd15, 16'h0000);
    tick();
    chk_out("bp.end", 1'b0, 4'd15, 16'h0000);

    // Set/clear collision on bit 3
    REQ = 16'h0008;
    tick();
    chk_out("coll.cap", 1'b0, 4'd15, 16'h0008);
    tick();
    chk_out("coll.first", 1'b1, 4'd3, 16'h0008);
    REQ = 16'h0000;
    tick();
    chk_out("coll.second", 1'b1, 4'd3, 16'h0000);
    tick();
    chk_out("coll.end", 1'b0, 4'd3, 16'h0000);
    check("coll.ptr", {12'd0, dut.ptr_r}, 16'd4);

    // Wrap-around: bring ptr to 14 then request 14, 0, 1
    do_reset();
    REQ = 16'h2000;
    tick();
    REQ = 16'h0000;
    tick();
    chk_out("wrap.13", 1'b1, 4'd13, 16'h0000);
    tick();
    check("wrap.ptr", {12'd0, dut.ptr_r}, 16'd14);
    REQ = 16'h4003;
    tick();
    REQ = 16'h0000;
    tick();
    chk_out("wrap.14", 1'b1, 4'd14, 16'h0003);
    tick();
    chk_out("wrap.0", 1'b1, 4'd0, 16'h0002);
    tick();
    chk_out("wrap.1", 1'b1, 4'd1, 16'h0000);
    tick();
    chk_out("wrap.end", 1'b0, 4'd1, 16'h0000);

    // EN=0 ignores requests
    EN = 1'b0; REQ = 16'hFFFF;
    tick();
    tick();
    chk_out("en0", 1'b0, 4'd1, 16'h0000);

    // Mid-operation reset with VALID high and pending non-zero
    EN = 1'b1; READY = 1'b0;
    tick();
    REQ = 16'h0000;
    tick();
    chk_out("mid.load", 1'b1, 4'd2, 16'hFFFB);
    RST_N = 1'b0; REQ = 16'hFFFF;
    tick();
    chk_out("mid.rst", 1'b0, 4'd0, 16'h0000);
    RST_N = 1'b1; REQ = 16'h0000;
    tick();
    chk_out("mid.after", 1'b0, 4'd0, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_encoder.md
# rr_encoder

Round-robin encoder: the reverse of the enabled one-hot decoder. Collects one-hot/multi-hot request pulses on `REQ` into a sticky pending vector, then issues them one at a time as binary indices on `OUT` through a valid/ready output register. Used wherever decoded request lines (interrupt lines, per-slot strobes) must be turned back into an index stream for a single consumer.

## Interface
- `EncodeWidth`, 4, width of the binary index on `OUT`
- `DecodeWidth`, 2**EncodeWidth, number of request lines; derived, not overridden
- `CLK`  input  1  rising-edge clock
- `RST_N`  input  1  reset; synchronous and active-low
- `EN`  input  1  request capture enable; `REQ` ignored when 0
- `REQ`  input  DecodeWidth  request pulses; any number of bits per cycle
- `OUT`  output  EncodeWidth  binary index of the issued request; registered
- `VALID`  output  1  `OUT` holds an issued request
- `READY`  input  1  consumer accepts `OUT` when `VALID & READY`
- `PEND`  output  DecodeWidth  pending vector; registered

## Operation
- Registers:
  - `pend[DecodeWidth]`
  - `ptr[EncodeWidth]`
  - output register (`OUT`, `VALID`)
- Capture: at each edge, if `EN=1`, then `pend |= REQ`.
- Load condition: `load = (VALID==0 | READY==1) & (pend != 0)`.
- Selection: first set bit of `pend` at or above `ptr`, wrapping modulo DecodeWidth. Combinational, from the registered `pend` only; same-cycle `REQ` is not considered.
- On load:
  - `OUT <= sel`, `VALID <= 1`
  - clear `pend[sel]`
  - `ptr <= sel+1`, wrapping from DecodeWidth-1 to 0
- Handshake with nothing to load (`VALID & READY & pend==0`): `VALID <= 0`, `OUT` holds its last value.
- Stall (`VALID & !READY`): `OUT`, `VALID` and `ptr` hold.
- Simultaneous set and clear of the same pend bit (`EN & REQ[sel]` while loading `sel`): the set wins and the bit stays pending. No request is lost.
- Repeated `REQ` on an already pending bit: merged, issued once.
- `EN=0`: capture stops. Pending requests and the output register still drain normally.
- Reset is synchronous and active-low. When `RST_N=0` at an edge:
  - `pend=0`, `ptr=0`, `VALID=0`, `OUT=0`
  - `REQ` in that cycle is discarded
  - an in-flight `VALID` is dropped without handshake

## Timing
- REQ→VALID latency: 2 cycles from the REQ edge if the output stage is free. Capture at edge N, load at edge N+1.
- Throughput: one index per cycle under continuous `READY=1` with pend non-empty. No bubble between back-to-back issues.
- `VALID` may rise regardless of `READY`. Once `VALID=1`, `OUT` is stable until the cycle after the handshake.
- Fairness: a pending bit waits at most DecodeWidth-1 other issues before it is issued.
- `PEND` reflects the registered pend vector, 1 cycle after capture.

## Structure
- Shared package `rr_encoder_pkg` holds:
  - the function `rr_first(vec, ptr)`: returns `{found, index}`, rotate-then-priority-encode
  - localparams derived from EncodeWidth
- Sub-module `rr_pick`: combinational round-robin selector (pend, ptr → sel, found), instantiated once. Reusable by future arbiters.
- Top level contains only the capture, the pointer and the output register.

## Test plan
- **Reset, then single request.** Stimulus: `RST_N` low 2 cycles; `EN=1`, `REQ=16'h0020` for 1 cycle; `READY=1`. Response: `VALID` rises 2 cycles after the REQ edge with `OUT=5`; `PEND=0` afterwards; `ptr=6`.
- **Multi-hot burst, round robin.** Stimulus: `REQ=16'h8421` in one cycle, `READY=1`. Response: `OUT` sequence 0, 5, 10, 15 on consecutive cycles; `VALID` then drops.
- **Backpressure.** Stimulus: same burst with `READY=0` for 5 cycles. Response: `OUT=0` held stable with `VALID=1`; `PEND=16'h8420`; after `READY` rises, 5, 10, 15 follow with no bubble.
- **Set/clear collision.** Stimulus: `pend=16'h0008`, `READY=1`, and `REQ=16'h0008` in the load cycle. Response: `OUT=3` issued twice, 1 cycle apart.
- **Wrap-around and fairness.** Stimulus: `ptr=14`, `REQ=16'h4003`. Response: order 14, 0, 1.
- **EN and mid-operation reset.** Stimulus: `EN=0` with `REQ=16'hFFFF`. Response: nothing captured. Stimulus: reset while `VALID=1` and `PEND` non-zero. Response: next cycle `VALID=0`, `OUT=0`, `PEND=0`.
